bus_xfer_ctrl: RTL and testbench

Control sequencer that moves one word across the shared tristate data bus per request: from a source register or an immediate value into a destination register. It sits directly upstream of the bank of bus registers and generates every chip-select, output-enable and load-enable they consume. It guarantees exactly one bus driver at a time and a clean drive, latch, release ordering. Requests come from the instruction decoder via a valid/ready handshake.

---
 rtl/bus_xfer_ctrl_pkg.sv | 18 +
 rtl/bus_xfer_ctrl_if.sv | 29 ++
 rtl/bus_xfer_ctrl_sel_decoder.sv | 17 +
 rtl/bus_xfer_ctrl.sv | 115 +++++++++++
 tb/tb_bus_xfer_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared definitions for the bus transfer sequencer: state encoding,
// default bus width and the register-select width helper.
package bus_xfer_ctrl_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    LATCH   = 2'd2,
    RELEASE = 2'd3
  } xfer_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request handshake and per-register strobes between the instruction
// decoder, the transfer sequencer and the bus register bank.
interface bus_xfer_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned SEL_W      = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [SEL_W-1:0]      req_src;
  logic [SEL_W-1:0]      req_dst;
  logic                  req_imm;
  logic [DATA_WIDTH-1:0] imm_data;
  logic [NUM_REGS-1:0]   cs;
  logic [NUM_REGS-1:0]   oe;
  logic [NUM_REGS-1:0]   en;
  logic                  done;
  logic                  err;

  modport master (
    input  req_valid, req_src, req_dst, req_imm, imm_data,
    output req_ready, cs, oe, en, done, err
  );

  modport slave (
    output req_valid, req_src, req_dst, req_imm, imm_data,
    input  req_ready, cs, oe, en, done, err
  );
endinterface

// File: rtl/bus_xfer_ctrl_sel_decoder.sv
// Binary select to one-hot strobe decoder; indices at or beyond NUM_REGS
// decode to all zero.
module sel_decoder #(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] oh
);
  always_comb begin
    oh = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en && (sel == SEL_W'(i))) oh[i] = 1'b1;
    end
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequencer moving one word per request over the shared tristate bus:
// drive source, latch destination, release, with registered strobes.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned SEL_W      = sel_width(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_xfer_ctrl_if.master       bus,
  inout  wire  [DATA_WIDTH-1:0] data
);
  xfer_state_e           state_q, state_d;
  logic [SEL_W-1:0]      src_q, src_d, dst_q, dst_d;
  logic                  imm_q, imm_d, rej_q, rej_d;
  logic [DATA_WIDTH-1:0] imm_data_q, imm_data_d;
  logic [NUM_REGS-1:0]   cs_q, cs_d, oe_q, oe_d, en_q, en_d;
  logic                  done_q, done_d, err_q, err_d, drive_q, drive_d;
  logic                  req_bad, active, src_sel_en, dst_sel_en;
  logic [NUM_REGS-1:0]   src_oh, dst_oh;

  assign req_bad = (32'(bus.req_dst) >= NUM_REGS)
                || (!bus.req_imm && (32'(bus.req_src) >= NUM_REGS))
                || (!bus.req_imm && (bus.req_src == bus.req_dst));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    imm_data_d = imm_data_q;
    rej_d      = rej_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          src_d      = bus.req_src;
          dst_d      = bus.req_dst;
          imm_d      = bus.req_imm;
          imm_data_d = bus.imm_data;
          rej_d      = req_bad;
          state_d    = req_bad ? RELEASE : DRIVE;
        end
      end
      DRIVE:   state_d = LATCH;
      LATCH:   state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are computed from the next state so every output is a flop.
  always_comb begin
    active     = (state_d != IDLE) && !rej_d;
    src_sel_en = active && !imm_d;
    dst_sel_en = active && (state_d == LATCH);
    cs_d       = src_oh | dst_oh;
    oe_d       = src_oh;
    en_d       = dst_oh;
    drive_d    = active && imm_d;
    done_d     = (state_d == RELEASE);
    err_d      = done_d && rej_d;
  end

  sel_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_src_dec (
    .sel (src_d),
    .en  (src_sel_en),
    .oh  (src_oh)
  );

  sel_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dst_dec (
    .sel (dst_d),
    .en  (dst_sel_en),
    .oh  (dst_oh)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= 1'b0;
      imm_data_q <= '0;
      rej_q      <= 1'b0;
      cs_q       <= '0;
      oe_q       <= '0;
      en_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      imm_data_q <= imm_data_d;
      rej_q      <= rej_d;
      cs_q       <= cs_d;
      oe_q       <= oe_d;
      en_q       <= en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      drive_q    <= drive_d;
    end
  end

  assign data          = drive_q ? imm_data_q : 'z;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.cs        = cs_q;
  assign bus.oe        = oe_q;
  assign bus.en        = en_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench: register bank model on a pulled-up bus, hand-computed
// strobe/data expectations per cycle, and a per-cycle contention monitor.
module tb_bus_xfer_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.DATA_WIDTH(8), .NUM_REGS(4), .SEL_W(2)) bus_a ();
  bus_xfer_ctrl_if #(.DATA_WIDTH(8), .NUM_REGS(3), .SEL_W(2)) bus_b ();
  wire [7:0] data_a;
  wire [7:0] data_b;

  bus_xfer_ctrl #(.DATA_WIDTH(8), .NUM_REGS(4), .SEL_W(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .data  (data_a)
  );

  bus_xfer_ctrl #(.DATA_WIDTH(8), .NUM_REGS(3), .SEL_W(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .data  (data_b)
  );

  // Released bus reads as 8'hFF; no stored or immediate value uses 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_a[g]);
    pullup (data_b[g]);
  end

  logic [7:0] regs [4];
  logic       pre_we;
  logic [1:0] pre_idx;
  logic [7:0] pre_val;

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign data_a = (bus_a.cs[g] && bus_a.oe[g]) ? regs[g] : 8'hzz;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pre_we && (pre_idx == 2'(i))) regs[i] <= pre_val;
      else if (bus_a.cs[i] && bus_a.en[i]) regs[i] <= data_a;
    end
  end

  logic mon_en    = 1'b0;
  logic imm_phase = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (($countones(bus_a.oe) <= 1) && ($countones(bus_a.en) <= 1)
              && ((bus_a.oe & bus_a.en) == 4'b0) && !(imm_phase && (bus_a.oe != 4'b0)))
      else begin
        errors++;
        $error("FAIL contention: observed oe=%b en=%b imm=%0d, expected oe/en one-hot-or-zero, disjoint, no oe during immediate",
               bus_a.oe, bus_a.en, imm_phase);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] cs, input logic [3:0] oe,
                       input logic [3:0] en, input logic done, input logic [7:0] d);
    chk({tag, "_cs"}, bus_a.cs, cs);
    chk({tag, "_oe"}, bus_a.oe, oe);
    chk({tag, "_en"}, bus_a.en, en);
    chk({tag, "_done"}, bus_a.done, done);
    chk({tag, "_data"}, data_a, d);
  endtask

  task automatic preload(input logic [1:0] idx, input logic [7:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    step();
    pre_we  = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] src, input logic [1:0] dst,
                         input logic imm, input logic [7:0] d);
    bus_a.req_valid = 1'b1;
    bus_a.req_src   = src;
    bus_a.req_dst   = dst;
    bus_a.req_imm   = imm;
    bus_a.imm_data  = d;
  endtask

  initial begin
    reset = 1'b0;
    pre_we = 1'b0; pre_idx = 2'd0; pre_val = 8'h00;
    bus_a.req_valid = 1'b0; bus_a.req_src = 2'd0; bus_a.req_dst = 2'd0;
    bus_a.req_imm = 1'b0; bus_a.imm_data = 8'h00;
    bus_b.req_valid = 1'b0; bus_b.req_src = 2'd0; bus_b.req_dst = 2'd0;
    bus_b.req_imm = 1'b0; bus_b.imm_data = 8'h00;
    step(); step();

    chk("rst_ready", bus_a.req_ready, 1);
    chk_a("rst", 4'b0, 4'b0, 4'b0, 1'b0, 8'hFF);
    chk("rst_err", bus_a.err, 0);
    chk("rst_b_ready", bus_b.req_ready, 1);

    reset  = 1'b1;
    mon_en = 1'b1;
    preload(2'd0, 8'h22);
    preload(2'd1, 8'hA5);
    preload(2'd2, 8'h11);
    preload(2'd3, 8'h66);

    // Register move 1 -> 2; imm_data differs so a stray drive would show.
    set_req(2'd1, 2'd2, 1'b0, 8'h5A);
    step();
    bus_a.req_valid = 1'b0;
    chk("mv_c1_ready", bus_a.req_ready, 0);
    chk_a("mv_c1", 4'b0010, 4'b0010, 4'b0000, 1'b0, 8'hA5);
    step();
    chk_a("mv_c2", 4'b0110, 4'b0010, 4'b0100, 1'b0, 8'hA5);
    step();
    chk_a("mv_c3", 4'b0010, 4'b0010, 4'b0000, 1'b1, 8'hA5);
    chk("mv_c3_err", bus_a.err, 0);
    chk("mv_reg2", regs[2], 8'hA5);
    step();
    chk("mv_c4_ready", bus_a.req_ready, 1);
    chk_a("mv_c4", 4'b0, 4'b0, 4'b0, 1'b0, 8'hFF);

    // Immediate 8'h3C -> reg0; src field is ignored.
    set_req(2'd3, 2'd0, 1'b1, 8'h3C);
    imm_phase = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    bus_a.imm_data  = 8'h00;
    chk_a("imm_c1", 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h3C);
    step();
    chk_a("imm_c2", 4'b0001, 4'b0000, 4'b0001, 1'b0, 8'h3C);
    step();
    chk_a("imm_c3", 4'b0000, 4'b0000, 4'b0000, 1'b1, 8'h3C);
    chk("imm_reg0", regs[0], 8'h3C);
    step();
    imm_phase = 1'b0;
    chk_a("imm_c4", 4'b0, 4'b0, 4'b0, 1'b0, 8'hFF);
    chk("imm_c4_ready", bus_a.req_ready, 1);

    // Rejected: src == dst.
    set_req(2'd2, 2'd2, 1'b0, 8'h00);
    step();
    bus_a.req_valid = 1'b0;
    chk_a("rej_c1", 4'b0, 4'b0, 4'b0, 1'b1, 8'hFF);
    chk("rej_c1_err", bus_a.err, 1);
    step();
    chk("rej_c2_ready", bus_a.req_ready, 1);
    chk("rej_c2_done", bus_a.done, 0);
    chk("rej_c2_err", bus_a.err, 0);
    chk("rej_reg2", regs[2], 8'hA5);

    // Rejected: dst index beyond a 3-register bank.
    bus_b.req_valid = 1'b1;
    bus_b.req_src   = 2'd0;
    bus_b.req_dst   = 2'd3;
    step();
    bus_b.req_valid = 1'b0;
    chk("rejb_done", bus_b.done, 1);
    chk("rejb_err", bus_b.err, 1);
    chk("rejb_strobes", {bus_b.cs, bus_b.oe, bus_b.en}, 9'b0);
    chk("rejb_data", data_b, 8'hFF);
    step();
    chk("rejb_ready", bus_b.req_ready, 1);
    chk("rejb_done_clr", bus_b.done, 0);

    // Back-to-back with req_valid held: 1->3, 2->0, imm 8'h77 -> 1.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       set_req(2'd1, 2'd3, 1'b0, 8'h00);
        1:       set_req(2'd2, 2'd0, 1'b0, 8'h00);
        default: set_req(2'd0, 2'd1, 1'b1, 8'h77);
      endcase
      imm_phase = (k == 2);
      chk($sformatf("b2b%0d_ready_idle", k), bus_a.req_ready, 1);
      step();
      chk($sformatf("b2b%0d_busy", k), bus_a.req_ready, 0);
      chk($sformatf("b2b%0d_c1_done", k), bus_a.done, 0);
      step(); step();
      chk($sformatf("b2b%0d_c3_done", k), bus_a.done, 1);
      step();
    end
    bus_a.req_valid = 1'b0;
    imm_phase = 1'b0;
    chk("b2b_reg0", regs[0], 8'hA5);
    chk("b2b_reg1", regs[1], 8'h77);
    chk("b2b_reg3", regs[3], 8'hA5);
    chk("b2b_end_ready", bus_a.req_ready, 1);

    // Reset asserted while in LATCH of move 3 -> 2.
    preload(2'd3, 8'h66);
    set_req(2'd3, 2'd2, 1'b0, 8'h00);
    step();
    bus_a.req_valid = 1'b0;
    step();
    chk_a("rl_c2", 4'b1100, 4'b1000, 4'b0100, 1'b0, 8'h66);
    reset = 1'b0;
    step();
    chk_a("rl_rst", 4'b0, 4'b0, 4'b0, 1'b0, 8'hFF);
    step();
    chk("rl_rst_done", bus_a.done, 0);
    reset = 1'b1;
    step();
    chk("rl_ready", bus_a.req_ready, 1);
    chk_a("rl_after", 4'b0, 4'b0, 4'b0, 1'b0, 8'hFF);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
